// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with HI/LO results
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] data2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
   logic [WIDTH:0] mul_sum, div_trial;
   logic div_q, div_d, sa_q, sa_d, sb_q, sb_d;
   logic dzp_q, dzp_d, dz_q, dz_d, done_q, done_d;
   logic sgn_a, sgn_b;
   always_comb begin
      sgn_a = op[0] & data1[WIDTH-1];
      sgn_b = op[0] & data2[WIDTH-1];
      abs_a = sgn_a ? -data1 : data1;
      abs_b = sgn_b ? -data2 : data2;
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      // acc holds {remainder, dividend/quotient}; the trial uses the shifted remainder
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
      prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo = dzp_q ? '1 : (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dzp_d   = dzp_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = op[1];
            sa_d    = sgn_a;
            sb_d    = sgn_b;
            a_d     = abs_a;
            b_d     = abs_b;
            acc_d   = {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            dzp_d   = op[1] && (data2 == '0);
            dz_d    = 1'b0;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            acc_d = div_q ? (div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                              : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                          : {mul_sum, acc_q[WIDTH-1:1]};
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            hi_d    = div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = div_q ? quo : prod[WIDTH-1:0];
            dz_d    = dzp_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dzp_q   <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dzp_q   <= dzp_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
   logic clk, reset, start, busy, done, div_by_zero;
   logic [1:0] op;
   logic [31:0] data1, data2, hi, lo;
   int total = 0;
   int bad = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .data1(data1), .data2(data2),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, b,
                                     output logic [31:0] eh, el, output logic edz);
      logic [63:0] pu;
      longint ps;
      int qs, rs;
      edz = 1'b0;
      eh = '0;
      el = '0;
      if (o == 2'd0) begin
         pu = {32'b0, a} * {32'b0, b};
         eh = pu[63:32];
         el = pu[31:0];
      end else if (o == 2'd1) begin
         ps = longint'($signed(a)) * longint'($signed(b));
         pu = ps;
         eh = pu[63:32];
         el = pu[31:0];
      end else if (b == 0) begin
         edz = 1'b1;
         eh = a;
         el = 32'hFFFFFFFF;
      end else if (o == 2'd2) begin
         eh = a % b;
         el = a / b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         eh = 0;
         el = 32'h80000000;
      end else begin
         qs = $signed(a) / $signed(b);
         rs = $signed(a) % $signed(b);
         eh = rs;
         el = qs;
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Drives one request from a post-edge point and returns at the done cycle (or after a timeout).
   task automatic launch(input logic [1:0] o, input logic [31:0] a, b, output int lat,
                         output logic [31:0] h, l, output logic dz, bs1, dz1);
      int n;
      op = o;
      data1 = a;
      data2 = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      bs1 = busy;
      dz1 = div_by_zero;
      n = 0;
      lat = -1;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (done) begin
            lat = n;
            break;
         end
      end
      h = hi;
      l = lo;
      dz = div_by_zero;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      op = 2'd0;
      data1 = '0;
      data2 = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
      end
      total++;
      if ({hi, lo} !== 64'h0) begin
         bad++;
         $display("FAIL reset_hilo: got %h want 0", {hi, lo});
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [1:0] vo[8] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
      logic [31:0] va[8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h64,
                             32'h80000000, 32'hFFFFFFF9, 32'h80000000};
      logic [31:0] vb[8] = '{32'd2, 32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h80000000};
      logic [31:0] vh[8] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'h64, 32'h0,
                             32'hFFFFFFF9, 32'h40000000};
      logic [31:0] vl[8] = '{32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF,
                             32'h80000000, 32'hFFFFFFFF, 32'h0};
      logic vz[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat;
      logic [31:0] h, l;
      logic dz, bs1, dz1, prev_dz;
      prev_dz = 1'b0;
      for (int i = 0; i < 8; i++) begin
         launch(vo[i], va[i], vb[i], lat, h, l, dz, bs1, dz1);
         total++;
         if (lat !== 33 || bs1 !== 1'b1) begin
            bad++;
            $display("FAIL dir%0d_latency: got lat=%0d busy=%b want lat=33 busy=1", i, lat, bs1);
         end
         total++;
         if ({h, l, dz} !== {vh[i], vl[i], vz[i]}) begin
            bad++;
            $display("FAIL dir%0d_result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                     i, h, l, dz, vh[i], vl[i], vz[i]);
         end
         if (prev_dz) begin
            total++;
            if (dz1 !== 1'b0) begin
               bad++;
               $display("FAIL dir%0d_dz_clear: got %b want 0", i, dz1);
            end
         end
         prev_dz = vz[i];
         @(posedge clk);
         #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== {vh[i], vl[i]}) begin
            bad++;
            $display("FAIL dir%0d_after: got done=%b busy=%b hi=%h lo=%h want done=0 busy=0 held",
                     i, done, busy, hi, lo);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [31:0] a, b, h, l, eh, el;
      logic [1:0] o;
      logic dz, bs1, dz1, edz;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = pick();
         b = pick();
         ref_model(o, a, b, eh, el, edz);
         launch(o, a, b, lat, h, l, dz, bs1, dz1);
         total++;
         if (lat !== 33 || {h, l, dz} !== {eh, el, edz}) begin
            bad++;
            $display("FAIL rnd%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b want lat=33 hi=%h lo=%h dz=%b",
                     i, o, a, b, lat, h, l, dz, eh, el, edz);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int pulses;
      logic [31:0] h, l, eh, el;
      logic edz;
      ref_model(2'd0, 32'h12345678, 32'h9ABCDEF0, eh, el, edz);
      op = 2'd0;
      data1 = 32'h12345678;
      data2 = 32'h9ABCDEF0;
      start = 1'b1;
      @(posedge clk);
      #1;
      op = 2'd3;
      data1 = 32'hFFFFFFFF;
      data2 = 32'h00000003;
      repeat (5) @(posedge clk);
      #1;
      start = 1'b0;
      pulses = 0;
      h = '0;
      l = '0;
      for (int k = 0; k < 60; k++) begin
         if (done) begin
            pulses++;
            h = hi;
            l = lo;
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (pulses !== 1) begin
         bad++;
         $display("FAIL busy_ignore_pulses: got %0d want 1", pulses);
      end
      total++;
      if ({h, l} !== {eh, el}) begin
         bad++;
         $display("FAIL busy_ignore_result: got hi=%h lo=%h want hi=%h lo=%h", h, l, eh, el);
      end
   endtask

   task automatic test_reset_mid();
      int pulses, lat;
      logic [31:0] h, l;
      logic dz, bs1, dz1;
      op = 2'd1;
      data1 = 32'h00001234;
      data2 = 32'hFFFF0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses);
      end
      launch(2'd2, 32'd100, 32'd7, lat, h, l, dz, bs1, dz1);
      total++;
      if (lat !== 33 || {h, l, dz} !== {32'd2, 32'd14, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_divu: got lat=%0d hi=%h lo=%h dz=%b want lat=33 hi=2 lo=14 dz=0",
                  lat, h, l, dz);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
